// File: rtl/bus_fairness_monitor_pkg.sv
// Shared types, defaults and width helpers for the bus fairness/liveness monitor.
package bus_fairness_pkg;

    localparam int DEF_MAX_CMD_STALL   = 4;
    localparam int DEF_MAX_RSP_WAIT    = 4;
    localparam int DEF_MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic drop;
        logic unexp;
        logic ovf;
    } err_flags_t;

    // Width needed to hold the larger of two limits (the value itself must fit).
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bus_fairness_monitor_if.sv
// Per-channel command/response handshake bundle observed by the fairness monitor.
interface bus_fairness_monitor_if #(
    parameter int NUM_CH = 2
);
    import bus_fairness_pkg::*;

    logic [NUM_CH-1:0] cmd_valid;
    logic [NUM_CH-1:0] cmd_ready;
    logic [NUM_CH-1:0] cmd_wr;
    logic [NUM_CH-1:0] rsp_valid;

    modport master (
        output cmd_valid,
        output cmd_ready,
        output cmd_wr,
        output rsp_valid
    );

    modport slave (
        input cmd_valid,
        input cmd_ready,
        input cmd_wr,
        input rsp_valid
    );

endinterface

// File: rtl/bus_fairness_monitor_channel.sv
// Single-channel stall/wait counters, owed-response tracking and sticky protocol flags.
module bus_fairness_channel
    import bus_fairness_pkg::*;
#(
    parameter int MAX_CMD_STALL   = DEF_MAX_CMD_STALL,
    parameter int MAX_RSP_WAIT    = DEF_MAX_RSP_WAIT,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter bit RSP_ON_WRITE    = 1'b0,
    parameter int CNT_W           = clog2_max(MAX_CMD_STALL, MAX_RSP_WAIT),
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             cmdValid,
    input  logic             cmdReady,
    input  logic             cmdWr,
    input  logic             rspValid,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] waitCnt,
    output logic [OUT_W-1:0] outCnt,
    output err_flags_t       errFlags,
    output logic             withinLimits
);

    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_CMD_STALL);
    localparam logic [CNT_W-1:0] WAIT_LIM  = CNT_W'(MAX_RSP_WAIT);
    localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] stallCntReg, stallCntNext;
    logic [CNT_W-1:0] waitCntReg,  waitCntNext;
    logic [OUT_W-1:0] outCntReg,   outCntNext;
    err_flags_t       errReg,      errNext;
    logic             prevStallReg, prevStallNext;

    logic accepted;
    logic owes;
    logic stalled;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCntReg  <= '0;
            waitCntReg   <= '0;
            outCntReg    <= '0;
            errReg       <= '0;
            prevStallReg <= 1'b0;
        end else if (en) begin
            stallCntReg  <= stallCntNext;
            waitCntReg   <= waitCntNext;
            outCntReg    <= outCntNext;
            errReg       <= errNext;
            prevStallReg <= prevStallNext;
        end
    end

    always_comb begin
        accepted      = cmdValid & cmdReady;
        owes          = accepted & (~cmdWr | RSP_ON_WRITE);
        stalled       = cmdValid & ~cmdReady;

        stallCntNext  = '0;
        waitCntNext   = '0;
        outCntNext    = outCntReg;
        errNext       = errReg;
        prevStallNext = stalled;

        if (stalled) begin
            stallCntNext = (stallCntReg == CNT_SAT) ? stallCntReg : stallCntReg + 1'b1;
        end

        // A same-cycle accept and response cancel out: the response retires the oldest entry.
        case ({owes, rspValid})
            2'b10: begin
                if (outCntReg == OUT_MAX) begin
                    errNext.ovf = 1'b1;
                end else begin
                    outCntNext = outCntReg + 1'b1;
                end
            end
            2'b01: begin
                if (outCntReg == '0) begin
                    errNext.unexp = 1'b1;
                end else begin
                    outCntNext = outCntReg - 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Measures the gap since the last response, restarting on every beat.
        if ((outCntNext != '0) && !rspValid) begin
            waitCntNext = (waitCntReg == CNT_SAT) ? waitCntReg : waitCntReg + 1'b1;
        end

        if (prevStallReg && !cmdValid) begin
            errNext.drop = 1'b1;
        end
    end

    assign stallCnt     = stallCntReg;
    assign waitCnt      = waitCntReg;
    assign outCnt       = outCntReg;
    assign errFlags     = errReg;
    assign withinLimits = (stallCntReg < STALL_LIM) && (waitCntReg < WAIT_LIM);

endmodule

// File: rtl/bus_fairness_monitor.sv
// NUM_CH-channel bus fairness/liveness monitor; fair feeds a prover restrict/assume.
module bus_fairness_monitor
    import bus_fairness_pkg::*;
#(
    parameter int                NUM_CH          = 2,
    parameter int                MAX_CMD_STALL   = DEF_MAX_CMD_STALL,
    parameter int                MAX_RSP_WAIT    = DEF_MAX_RSP_WAIT,
    parameter int                MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter logic [NUM_CH-1:0] RSP_ON_WRITE    = '0,
    parameter int                CNT_W           = clog2_max(MAX_CMD_STALL, MAX_RSP_WAIT),
    parameter int                OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    trap,
    bus_fairness_monitor_if.slave   bus,
    output logic                    fair,
    output logic [NUM_CH*CNT_W-1:0] cmd_stall_cnt,
    output logic [NUM_CH*CNT_W-1:0] rsp_wait_cnt,
    output logic [NUM_CH*OUT_W-1:0] outstanding,
    output logic [NUM_CH-1:0]       err_drop,
    output logic [NUM_CH-1:0]       err_unexp,
    output logic [NUM_CH-1:0]       err_ovf
);

    logic [NUM_CH-1:0] withinLimits;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gChannel
            err_flags_t chErr;

            bus_fairness_channel #(
                .MAX_CMD_STALL   (MAX_CMD_STALL),
                .MAX_RSP_WAIT    (MAX_RSP_WAIT),
                .MAX_OUTSTANDING (MAX_OUTSTANDING),
                .RSP_ON_WRITE    (RSP_ON_WRITE[gi]),
                .CNT_W           (CNT_W),
                .OUT_W           (OUT_W)
            ) uChannel (
                .clock        (clock),
                .reset_n      (reset_n),
                .en           (en),
                .cmdValid     (bus.cmd_valid[gi]),
                .cmdReady     (bus.cmd_ready[gi]),
                .cmdWr        (bus.cmd_wr[gi]),
                .rspValid     (bus.rsp_valid[gi]),
                .stallCnt     (cmd_stall_cnt[gi*CNT_W +: CNT_W]),
                .waitCnt      (rsp_wait_cnt[gi*CNT_W +: CNT_W]),
                .outCnt       (outstanding[gi*OUT_W +: OUT_W]),
                .errFlags     (chErr),
                .withinLimits (withinLimits[gi])
            );

            assign err_drop[gi]  = chErr.drop;
            assign err_unexp[gi] = chErr.unexp;
            assign err_ovf[gi]   = chErr.ovf;
        end
    endgenerate

    // Trap overrides immediately; the limit checks come straight from registered counts.
    assign fair = ~trap & (&withinLimits);

endmodule

// File: doc/bus_fairness_monitor.md
Name: bus_fairness_monitor

Overview:
- Parametrised, synthesizable bus-fairness and liveness monitor for formal wrappers around CPU cores.
- Replaces ad-hoc per-bus stall counters in wrappers with one NUM_CH-channel block.
- Per channel: tracks command stall cycles, response wait cycles and outstanding-response count; flags protocol violations.
- Wrapper feeds `fair` into a restrict/assume, so the prover only explores bounded-latency bus behaviour.

Parameters:
- NUM_CH, 2, number of monitored cmd/rsp channels (e.g. ch0 = instruction bus, ch1 = data bus).
- MAX_CMD_STALL, 4, command may stall at most MAX_CMD_STALL-1 consecutive cycles while fair=1.
- MAX_RSP_WAIT, 4, response gap limit while a response is owed.
- MAX_OUTSTANDING, 2, maximum owed responses per channel; range 1..15.
- RSP_ON_WRITE, {NUM_CH{1'b0}}, per-channel mask; 1 = accepted writes also owe a response.
- CNT_W, $clog2(max(MAX_CMD_STALL,MAX_RSP_WAIT)+1), derived counter width; do not override.
- OUT_W, $clog2(MAX_OUTSTANDING+1), derived outstanding-count width; do not override.

Ports:
- clock, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- en, in, 1, monitor enable; 0 holds all state.
- trap, in, 1, core trap indication; forces fair low.
- cmd_valid, in, NUM_CH, command valid per channel.
- cmd_ready, in, NUM_CH, command ready per channel.
- cmd_wr, in, NUM_CH, command is a write.
- rsp_valid, in, NUM_CH, response beat per channel (one response each).
- fair, out, 1, all channels within limits and no trap.
- cmd_stall_cnt, out, NUM_CH*CNT_W, packed per-channel stall counters, ch0 in LSBs.
- rsp_wait_cnt, out, NUM_CH*CNT_W, packed per-channel wait counters.
- outstanding, out, NUM_CH*OUT_W, packed per-channel owed-response counts.
- err_drop, out, NUM_CH, sticky: cmd_valid deasserted before acceptance.
- err_unexp, out, NUM_CH, sticky: rsp_valid with nothing outstanding.
- err_ovf, out, NUM_CH, sticky: accept attempted at MAX_OUTSTANDING with no same-cycle response.

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-transaction): all counters, outstanding and error flags go to 0; the internal prev-stall flag goes to 0. fair therefore reads 1 once trap=0.
- en=0: all registers hold. Flags and fair still evaluate from the held state.
- Per channel c, on each clock edge with en=1:
  - acc = cmd_valid&cmd_ready.
  - owe = acc & (!cmd_wr | RSP_ON_WRITE[c]).
- Stall counter:
  - cmd_valid&!cmd_ready → increment, saturating at 2^CNT_W-1.
  - Otherwise → 0.
- Outstanding count (next value):
  - owe&!rsp_valid → +1.
  - rsp_valid&!owe → -1.
  - owe&rsp_valid → unchanged. The same-cycle response retires the older entry; with outstanding=0 this covers a zero-latency response.
- Outstanding boundaries:
  - At MAX_OUTSTANDING, owe&!rsp_valid → count stays at MAX_OUTSTANDING, set err_ovf.
  - At 0, rsp_valid&!owe → count stays 0, set err_unexp.
- Wait counter:
  - Next outstanding > 0 and no rsp_valid this cycle → increment, saturating.
  - rsp_valid, or next outstanding = 0 → 0. It restarts for each owed response (measures the gap, not the age of the oldest response).
- err_drop:
  - A registered prev_stall = cmd_valid&!cmd_ready from the last enabled cycle.
  - Set when prev_stall & !cmd_valid.
- All error flags are sticky until reset. They never depend on fair.
- fair (combinational from registers and trap): !trap & AND over c of (cmd_stall_cnt[c] < MAX_CMD_STALL & rsp_wait_cnt[c] < MAX_RSP_WAIT).
- Latency: counters and flags are visible one cycle after the causing input. fair follows trap in zero cycles.
- Channels are fully independent; no inter-channel arbitration.

Decomposition:
- Package bus_fairness_pkg holds:
  - function clog2_max(a,b) for CNT_W;
  - localparam defaults DEF_MAX_CMD_STALL=4, DEF_MAX_RSP_WAIT=4, DEF_MAX_OUTSTANDING=2;
  - typedef struct err_flags_t {drop, unexp, ovf}.
- One sub-module, bus_fairness_channel: single-channel counters, outstanding tracking and sticky flags. It exports a per-channel within_limits bit.
- Top-level generate-loops NUM_CH instances, packs their outputs, and ANDs within_limits with !trap to form fair.

Test Plan:
- Stall limit, defaults: ch0 cmd_valid=1, cmd_ready=0 for 5 cycles → cmd_stall_cnt[0] = 1,2,3,4,5 (saturates at 7 for CNT_W=3). fair drops to 0 on the cycle the count reaches 4. ready=1 → count 0, fair=1 next cycle.
- Back-to-back reads: ch1 accepts 2 reads in 2 cycles → outstanding=2. Third accept with no rsp → outstanding stays 2, err_ovf[1]=1. One rsp → outstanding=1, rsp_wait_cnt[1]=0.
- Zero-latency response: outstanding=0, accept read and rsp_valid in the same cycle → outstanding stays 0, no errors. Write accept with RSP_ON_WRITE=0 → outstanding unchanged.
- Protocol errors: rsp_valid on idle ch0 → err_unexp[0]=1, outstanding=0. cmd_valid high/ready low for 1 cycle, then valid=0 → err_drop[0]=1. Both flags persist 20 cycles.
- Wait limit plus trap: read accepted, no rsp for 4 cycles → rsp_wait_cnt reaches 4 and fair=0. Separately, trap=1 with all counts 0 → fair=0 in the same cycle.
- Reset and enable: reset_n pulsed low mid-stall with outstanding=2 and err flags set → all outputs 0 and fair=1 immediately. en=0 for 3 stalled cycles → cmd_stall_cnt frozen.
